// File: rtl/reg_dump_if.sv
// reg_dump_if: start request, register-file debug read port and byte stream toward the UART TX
interface reg_dump_if #(
    parameter int REGS = 5,
    parameter int NB   = 32
);
    logic            i_start;
    logic [NB-1:0]   i_reg_data;
    logic            i_tx_ready;
    logic [REGS-1:0] o_reg_addr;
    logic            o_tx_valid;
    logic [7:0]      o_tx_byte;
    logic            o_busy;
    logic            o_done;
    modport master (
        input  i_start, i_reg_data, i_tx_ready,
        output o_reg_addr, o_tx_valid, o_tx_byte, o_busy, o_done
    );
    modport slave (
        output i_start, i_reg_data, i_tx_ready,
        input  o_reg_addr, o_tx_valid, o_tx_byte, o_busy, o_done
    );
endinterface

// File: rtl/reg_dump_sequencer.sv
// reg_dump_sequencer: walks registers 0..TAM-1 and streams each one LSB byte first
module reg_dump_sequencer #(
    parameter int REGS = 5,
    parameter int NB   = 32,
    parameter int TAM  = 32
) (
    input logic        i_clk,
    input logic        i_reset,
    reg_dump_if.master bus
);
    localparam int NBY = NB / 8;
    localparam int CW  = $clog2(NBY + 1);
    typedef enum logic [1:0] {IDLE, LATCH, SEND, DONE} state_t;
    state_t          state, state_n;
    logic [NB-1:0]   sh;
    logic [CW-1:0]   cnt;
    logic [REGS-1:0] addr;
    logic            xfer, last_byte, last_reg;
    assign xfer      = state == SEND && bus.i_tx_ready;
    assign last_byte = cnt == CW'(NBY - 1);
    assign last_reg  = addr == REGS'(TAM - 1);
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = bus.i_start ? LATCH : IDLE;
            LATCH:   state_n = SEND;
            SEND:    state_n = xfer && last_byte ? (last_reg ? DONE : LATCH) : SEND;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
            sh    <= '0;
            cnt   <= '0;
            addr  <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE:  if (bus.i_start) addr <= '0;
                LATCH: begin
                    sh  <= bus.i_reg_data;
                    cnt <= '0;
                end
                SEND:  if (xfer) begin
                    sh  <= sh >> 8;
                    cnt <= cnt + 1'b1;
                    if (last_byte && !last_reg) addr <= addr + 1'b1;
                end
                default: addr <= '0;
            endcase
        end
    end
    // the shift register drains to zero, so the byte output idles at 0
    assign bus.o_reg_addr = addr;
    assign bus.o_tx_valid = state == SEND;
    assign bus.o_tx_byte  = sh[7:0];
    assign bus.o_busy     = state != IDLE;
    assign bus.o_done     = state == DONE;
endmodule

// File: tb/tb_reg_dump_sequencer.sv
// tb_reg_dump_sequencer: randomized dumps checked against a byte-stream model of the register file
module tb_reg_dump_sequencer;
    localparam int REGS = 5, NB = 32, TAM = 32, NBY = NB / 8;
    logic clk = 0, rst = 1;
    always #5 clk = ~clk;
    reg_dump_if #(.REGS(REGS), .NB(NB)) bus();
    reg_dump_sequencer #(.REGS(REGS), .NB(NB), .TAM(TAM)) dut (.i_clk(clk), .i_reset(rst), .bus(bus));
    logic [NB-1:0] mem [TAM];
    assign bus.i_reg_data = mem[bus.o_reg_addr];
    int errors = 0, checks = 0;
    byte unsigned got[$];
    int dones, done_at, first_v, cyc;
    bit hold;
    logic [7:0] hold_byte;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // sample between edges, then advance one clock
    task automatic tick();
        @(negedge clk);
        if (hold) begin
            chk("hold_valid", 64'(bus.o_tx_valid), 64'd1);
            chk("hold_byte", 64'(bus.o_tx_byte), 64'(hold_byte));
        end
        hold = bus.o_tx_valid && !bus.i_tx_ready && !rst;
        hold_byte = bus.o_tx_byte;
        if (bus.o_tx_valid && bus.i_tx_ready && !rst) got.push_back(bus.o_tx_byte);
        if (bus.o_done) begin
            dones++;
            done_at = cyc;
        end
        if (bus.o_tx_valid && first_v < 0) first_v = cyc;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_dump(int rmode, int stall_at, int start_at, int chg_at, int abort_at, int exp_done);
        int stalls = 0;
        bit pulsed = 0;
        got.delete();
        dones = 0; done_at = -1; first_v = -1; cyc = 0; hold = 0;
        bus.i_start = 1;
        bus.i_tx_ready = 1;
        tick();
        bus.i_start = 0;
        for (int n = 0; n < 2000 && dones == 0; n++) begin
            bus.i_tx_ready = rmode == 1 ? 1'($urandom_range(0, 1)) : 1'b1;
            if (got.size() == stall_at && bus.o_tx_valid && stalls < 7) begin
                bus.i_tx_ready = 0;
                stalls++;
            end
            if (!pulsed && got.size() == start_at && bus.o_tx_valid) begin
                bus.i_start = 1;
                pulsed = 1;
            end else bus.i_start = 0;
            if (got.size() == chg_at) mem[20] = 32'hDEADBEEF;
            if (got.size() == abort_at && bus.o_tx_valid) begin
                rst = 1;
                bus.i_tx_ready = 0;
                tick();
                rst = 0;
                bus.i_start = 0;
                chk("abort_valid", 64'(bus.o_tx_valid), 64'd0);
                chk("abort_busy", 64'(bus.o_busy), 64'd0);
                chk("abort_addr", 64'(bus.o_reg_addr), 64'd0);
                chk("abort_bytes", 64'(got.size()), 64'(abort_at));
                return;
            end
            tick();
        end
        bus.i_start = 0;
        chk("done_count", 64'(dones), 64'd1);
        if (exp_done > 0) chk("done_cycle", 64'(done_at), 64'(exp_done));
        chk("first_valid_cycle", 64'(first_v), 64'd2);
        chk("busy_after_done", 64'(bus.o_busy), 64'd0);
        chk("addr_after_done", 64'(bus.o_reg_addr), 64'd0);
        chk("byte_count", 64'(got.size()), 64'(TAM * NBY));
        for (int i = 0; i < got.size() && i < TAM * NBY; i++)
            chk($sformatf("byte%0d", i), 64'(got[i]), 64'(8'(mem[i / NBY] >> (8 * (i % NBY)))));
    endtask

    initial begin
        bus.i_start = 0;
        bus.i_tx_ready = 0;
        for (int i = 0; i < TAM; i++) mem[i] = NB'(i);
        tick();
        tick();
        chk("rst_valid", 64'(bus.o_tx_valid), 64'd0);
        chk("rst_busy", 64'(bus.o_busy), 64'd0);
        chk("rst_done", 64'(bus.o_done), 64'd0);
        chk("rst_addr", 64'(bus.o_reg_addr), 64'd0);
        chk("rst_byte", 64'(bus.o_tx_byte), 64'd0);
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            bus.i_tx_ready = 1'($urandom_range(0, 1));
            tick();
            chk("idle_busy", 64'(bus.o_busy), 64'd0);
            chk("idle_valid", 64'(bus.o_tx_valid), 64'd0);
        end
        run_dump(0, -1, -1, -1, -1, 161);
        run_dump(0, 20, -1, -1, -1, 168);
        for (int i = 0; i < TAM; i++) mem[i] = NB'($urandom);
        run_dump(1, -1, 40, 40, -1, -1);
        run_dump(0, -1, -1, -1, 50, -1);
        run_dump(1, -1, -1, -1, -1, -1);
        for (int i = 0; i < TAM; i++) mem[i] = NB'($urandom);
        run_dump(0, -1, -1, -1, -1, 161);
        run_dump(0, -1, -1, -1, -1, 161);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
